clk_stepper: RTL
================

# clk_stepper

Run/halt/step controller that sequences the computer core from the board buttons. It debounces the run and step buttons and runs a HALT/RUN/BURST state machine. It emits a one-cycle clock-enable `CE` for the core, paced by a rate tick from the clock generator, and counts the issued cycles. It sits between the button/switch capture logic and the `comp` instance. It replaces the "clock from button" path with a glitch-free enable on a single free-running clock.

## Interface
- `DEBOUNCE_CYCLES`, default 100000: consecutive `CLK` cycles a synchronized button level must be stable before it is accepted; legal range ≥ 1.
- `BURST_W`, default 16: width of `BURST_N` and of the internal remaining-steps counter.

- `CLK`  in  1  single system clock; all logic is on its rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `TICK`  in  1  rate pulse from the clock generator, one `CLK` cycle wide, any spacing (may be tied high).
- `BTN_RUN`  in  1  raw run/halt button, asynchronous, bouncy.
- `BTN_STEP`  in  1  raw step button, asynchronous, bouncy.
- `BURST_N`  in  `BURST_W`  enable pulses per step press; 0 is treated as 1; sampled on the accepted press.
- `HALT_REQ`  in  1  level from the core (breakpoint/halt port bit); forces HALT while high.
- `CE`  out  1  registered clock-enable for the core, one `CLK` cycle per executed core cycle.
- `RUNNING`  out  1  high in the RUN state.
- `BUSY`  out  1  high in the BURST state.
- `CYCLES`  out  32  number of `CE` pulses issued since reset; wraps at 2^32.

## Operation
- **Button path (per button):**
  - 2-flop synchronizer, then debounce counter and a `stable` register.
  - The counter clears whenever the synchronized level equals `stable`.
  - `stable` takes the new level after `DEBOUNCE_CYCLES` consecutive differing samples.
  - A press is a one-cycle registered pulse on each rising edge of `stable`. Releases generate nothing.
- **States:** HALT (reset state), RUN, BURST. Priority in every state: `HALT_REQ` > run press > step press > `TICK`.
- **HALT:**
  - run press with `HALT_REQ` low → RUN.
  - step press with `HALT_REQ` low → BURST, with remaining = `BURST_N` (or 1 if `BURST_N`==0).
  - Run and step pressed in the same cycle → RUN.
- **RUN:**
  - `CE` follows `TICK`.
  - `HALT_REQ` or run press → HALT; no `CE` is issued for a `TICK` in that cycle.
  - Step press is ignored.
- **BURST:**
  - Each `TICK` issues one `CE` and decrements remaining.
  - The `TICK` that takes remaining from 1 to 0 also moves the state to HALT.
  - `HALT_REQ` or run press aborts to HALT with no `CE`; remaining is discarded.
  - Step press is ignored.
- **CYCLES:** increments in the same edge that sets `CE` high. It is not cleared by state changes.
- **Reset values:** `CE`=0, `RUNNING`=0, `BUSY`=0, `CYCLES`=0, state HALT, remaining 0, all sync/debounce/stable registers 0.
  - Reset mid-burst or mid-debounce discards all progress.
  - A button held through reset release produces one press after debounce.

## Timing
- **Button latency:** let E0 be the first edge that samples a new raw level, stable thereafter.
  - `stable` updates at edge E(1+D), where D = `DEBOUNCE_CYCLES`.
  - The press pulse is high in the cycle after edge E(2+D).
  - The state changes at edge E(3+D).
- **Bounce rejection:** a raw pulse shorter than D cycles after synchronization produces no press.
- **`CE` latency:** `CE` is registered; a qualifying `TICK` high in cycle n gives `CE` high in cycle n+1 for exactly one cycle.
  - `RUNNING`/`BUSY` change on the same edge as the state.
- **Back-to-back `TICK`:** with `TICK` held high in RUN, `CE` is high every cycle. In BURST with `TICK` high, exactly N consecutive `CE` cycles are issued, then `BUSY` falls on the edge that raises the last `CE`.
- **`HALT_REQ` response:**
  - Rising in cycle n → state HALT at edge n+1.
  - `CE` is not asserted in cycle n+1 even if `TICK` was high in cycle n.
- **`CYCLES` wrap:** 0xFFFFFFFF + 1 → 0x00000000, with no flag.

## Test plan
- Reset then idle, with `TICK` toggling: `CE`, `RUNNING`, `BUSY` stay 0 and `CYCLES`=0 for 1000 cycles.
- `DEBOUNCE_CYCLES`=4. `BTN_RUN` bounces 1,0,1 with 2-cycle glitches, then holds high → exactly one press, `RUNNING`=1 at E7. `TICK` every 3 cycles → `CE` every 3 cycles, one cycle after each `TICK`.
- In HALT with `BURST_N`=5, `TICK` held high, press step → `BUSY`=1, exactly 5 consecutive `CE` cycles, `CYCLES`=5, then HALT. Repeat with `BURST_N`=0 → exactly 1 `CE`.
- RUN with `TICK` high; assert `HALT_REQ` in cycle n → last `CE` in cycle n, state HALT at n+1. Press run while `HALT_REQ` is high → stays HALT.
- BURST with `BURST_N`=100, `TICK` every 10 cycles. Press run after 3 `CE` pulses → HALT, `CYCLES`=3, no further `CE`. Assert `RESET` mid-burst → all outputs 0 immediately, with no clock edge required.
- Force `CYCLES` to 0xFFFFFFFE via `HALT_REQ` low and RUN with `TICK` high → after 2 `CE` pulses, `CYCLES`=0x00000000.

Source files
------------

// File: rtl/clk_stepper.sv
// clk_stepper: run/halt/step sequencer for the core. Debounces the run and
// step buttons, runs a HALT/RUN/BURST state machine and issues a registered
// one-cycle clock enable (CE) paced by TICK, counting every issued enable.
module clk_stepper #(
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int BURST_W         = 16
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               TICK,
   input  logic               BTN_RUN,
   input  logic               BTN_STEP,
   input  logic [BURST_W-1:0] BURST_N,
   input  logic               HALT_REQ,
   output logic               CE,
   output logic               RUNNING,
   output logic               BUSY,
   output logic [31:0]        CYCLES
);

   // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_HALT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_BURST = 2'd2
   } state_t;

   // Bit 0 is the run button, bit 1 the step button.
   logic [1:0] btn_raw;
   logic [1:0] press;

   assign btn_raw = {BTN_STEP, BTN_RUN};

   // One synchronizer + debouncer + rising-edge detector per button.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_btn
         logic             sync1_reg;
         logic             sync2_reg;
         logic             stable_reg;
         logic             stable_prev_reg;
         logic             press_reg;
         logic [CNT_W-1:0] cnt_reg;

         // Two-flop synchronizer for the asynchronous button level.
         always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
               sync1_reg <= 1'b0;
               sync2_reg <= 1'b0;
            end else begin
               sync1_reg <= btn_raw[gi];
               sync2_reg <= sync1_reg;
            end
         end

         // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
         always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
               cnt_reg    <= '0;
               stable_reg <= 1'b0;
            end else if (sync2_reg == stable_reg) begin
               cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
               cnt_reg    <= '0;
               stable_reg <= sync2_reg;
            end else begin
               cnt_reg <= cnt_reg + CNT_W'(1);
            end
         end

         // One-cycle press pulse on each rising edge of the debounced level.
         always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
               stable_prev_reg <= 1'b0;
               press_reg       <= 1'b0;
            end else begin
               stable_prev_reg <= stable_reg;
               press_reg       <= stable_reg & ~stable_prev_reg;
            end
         end

         assign press[gi] = press_reg;
      end
   endgenerate

   logic               run_press;
   logic               step_press;
   logic               abort;
   logic [BURST_W-1:0] burst_load;

   assign run_press  = press[0];
   assign step_press = press[1];
   // HALT_REQ and a run press both end RUN/BURST immediately.
   assign abort      = HALT_REQ | run_press;
   // A burst length of zero still executes one cycle.
   assign burst_load = (BURST_N == '0) ? BURST_W'(1) : BURST_N;

   state_t             state_reg;
   state_t             state_next;
   logic [BURST_W-1:0] remaining_reg;
   logic [BURST_W-1:0] remaining_next;
   logic               ce_reg;
   logic               ce_next;
   logic [31:0]        cycles_reg;

   // State register plus the registered CE, burst counter and cycle counter.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_reg     <= ST_HALT;
         remaining_reg <= '0;
         ce_reg        <= 1'b0;
         cycles_reg    <= '0;
      end else begin
         state_reg     <= state_next;
         remaining_reg <= remaining_next;
         ce_reg        <= ce_next;
         cycles_reg    <= cycles_reg + {31'd0, ce_next};
      end
   end

   // Next-state logic; priority is HALT_REQ, run press, step press, TICK.
   always_comb begin
      state_next     = state_reg;
      remaining_next = remaining_reg;
      case (state_reg)
         ST_HALT: begin
            if (!HALT_REQ) begin
               if (run_press) begin
                  state_next = ST_RUN;
               end else if (step_press) begin
                  state_next     = ST_BURST;
                  remaining_next = burst_load;
               end
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_next = ST_HALT;
            end
         end
         ST_BURST: begin
            if (abort) begin
               state_next     = ST_HALT;
               remaining_next = '0;
            end else if (TICK) begin
               remaining_next = remaining_reg - BURST_W'(1);
               if (remaining_reg == BURST_W'(1)) begin
                  state_next = ST_HALT;
               end
            end
         end
         default: begin
            state_next     = ST_HALT;
            remaining_next = '0;
         end
      endcase
   end

   // Output logic: a TICK issues CE only while running or bursting and not aborting.
   always_comb begin
      ce_next = 1'b0;
      if ((state_reg == ST_RUN || state_reg == ST_BURST) && TICK && !abort) begin
         ce_next = 1'b1;
      end
   end

   assign CE      = ce_reg;
   assign RUNNING = (state_reg == ST_RUN);
   assign BUSY    = (state_reg == ST_BURST);
   assign CYCLES  = cycles_reg;

endmodule
